// File: rtl/banked_register_file.sv
// Banked accumulator register file: NUM_BANKS GPR banks, ACC/STATUS context push/pop, DBAR/DOFF/IBAR/IOFF, two mux read ports.
// Latency: reads are combinational from pre-edge state; writes visible next cycle; push/pop completes in 2 cycles, with ctx_ack in the cycle after.
// Backpressure: ctx_busy drops all register writes and new requests; requests are also ignored while ctx_ack is high. Optional macro: REGFILE_DMAR_AUTOINC_EN.
module banked_register_file #(
  parameter int DATA_W         = 8,
  parameter int I_ADDR_WIDTH   = 12,
  parameter int D_ADDR_WIDTH   = 12,
  parameter int NUM_GPR        = 8,
  parameter int NUM_BANKS      = 4,
  parameter int REG_ADDR_WIDTH = 4,
  localparam int DEPTH_W       = $clog2(NUM_BANKS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  output logic [DATA_W-1:0]         acc_out,
  input  logic [DATA_W-1:0]         acc_in,
  input  logic                      acc_write_enable,
  input  logic                      acc_src_sel,
  input  logic                      put_enable,
  input  logic [REG_ADDR_WIDTH-1:0] put_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_W-1:0]         rd_data_a,
  output logic [DATA_W-1:0]         rd_data_b,
  input  logic                      status_write_enable,
  input  logic [3:0]                flags,
  input  logic                      dmar_inc,
  output logic [D_ADDR_WIDTH-1:0]   dmar,
  output logic [I_ADDR_WIDTH-1:0]   imar,
  input  logic                      ctx_push_req,
  input  logic                      ctx_pop_req,
  output logic                      ctx_ack,
  output logic                      ctx_busy,
  output logic [DEPTH_W-1:0]        ctx_depth,
  output logic                      ctx_err
);

  // Base registers hold the address bits above the DATA_W-wide offset.
  localparam int DBAR_W = D_ADDR_WIDTH - DATA_W;
  localparam int IBAR_W = I_ADDR_WIDTH - DATA_W;

  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_ACC    = REG_ADDR_WIDTH'(8);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_DBAR   = REG_ADDR_WIDTH'(9);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_DOFF   = REG_ADDR_WIDTH'(10);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_IBAR   = REG_ADDR_WIDTH'(11);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_IOFF   = REG_ADDR_WIDTH'(12);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_STATUS = REG_ADDR_WIDTH'(13);

  typedef enum logic [1:0] {
    CTX_IDLE = 2'd0,
    CTX_PUSH = 2'd1,
    CTX_POP  = 2'd2
  } ctx_state_t;

  ctx_state_t state;

  logic [DATA_W-1:0] gpr [NUM_BANKS][NUM_GPR];
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] status_nxt;
  logic [DBAR_W-1:0] dbar;
  logic [DATA_W-1:0] doff;
  logic [IBAR_W-1:0] ibar;
  logic [DATA_W-1:0] ioff;
  logic [DATA_W-1:0] shadow_acc    [NUM_BANKS];
  logic [DATA_W-1:0] shadow_status [NUM_BANKS];
  logic [DEPTH_W-1:0] depth;
  logic               busy;
  logic               ack;
  logic               err;

  // Write qualifiers: every architectural write is frozen while a context switch is in flight.
  logic put_ok;
  logic put_gpr;
  logic pop_load;
  logic push_legal;
  logic pop_legal;

  assign put_ok     = put_enable && !busy;
  assign put_gpr    = put_ok && (put_addr < REG_ADDR_WIDTH'(NUM_GPR));
  assign pop_load   = (state == CTX_POP);
  assign push_legal = ctx_push_req && !ctx_pop_req && (depth < DEPTH_W'(NUM_BANKS - 1));
  assign pop_legal  = ctx_pop_req && !ctx_push_req && (depth != '0);

  // Shared read decode; GPRs come from the bank selected by the current depth.
  function automatic logic [DATA_W-1:0] read_reg(input logic [REG_ADDR_WIDTH-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    for (int i = 0; i < NUM_GPR; i++) begin
      if (addr == REG_ADDR_WIDTH'(i)) val = gpr[depth][i];
    end
    case (addr)
      ADDR_ACC:    val = acc;
      ADDR_DBAR:   val = DATA_W'(dbar);
      ADDR_DOFF:   val = doff;
      ADDR_IBAR:   val = DATA_W'(ibar);
      ADDR_IOFF:   val = ioff;
      ADDR_STATUS: val = status;
      default:     ;
    endcase
    return val;
  endfunction

  // Two independent combinational read ports, no bypass from same-cycle writes.
  always_comb begin
    rd_data_a = read_reg(rd_addr_a);
    rd_data_b = read_reg(rd_addr_b);
  end

  // STATUS next value: a PUT supplies all bits, ALU flags then win on the low nibble.
  always_comb begin
    status_nxt = status;
    if (put_ok && (put_addr == ADDR_STATUS)) status_nxt = acc;
    if (status_write_enable) status_nxt[3:0] = flags;
  end

  // ACC: restored from the shadow on pop, otherwise loaded from acc_in or read port A.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (pop_load) begin
      acc <= shadow_acc[depth - DEPTH_W'(1)];
    end else if (acc_write_enable && !busy) begin
      acc <= acc_src_sel ? rd_data_a : acc_in;
    end
  end

  // STATUS: restored on pop, otherwise updated from PUT and ALU flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status <= '0;
    end else if (pop_load) begin
      status <= shadow_status[depth - DEPTH_W'(1)];
    end else if (!busy) begin
      status <= status_nxt;
    end
  end

  // Banked GPRs: a PUT lands in the active bank only; other banks hold their contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int i = 0; i < NUM_GPR; i++) begin
          gpr[b][i] <= '0;
        end
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int i = 0; i < NUM_GPR; i++) begin
          if (put_gpr && (depth == DEPTH_W'(b)) && (put_addr == REG_ADDR_WIDTH'(i))) begin
            gpr[b][i] <= acc;
          end
        end
      end
    end
  end

`ifdef REGFILE_DMAR_AUTOINC_EN
  // DMAR increment treats {DBAR,DOFF} as one counter so the offset carry reaches the base.
  logic [D_ADDR_WIDTH-1:0] dmar_next;
  logic                    inc_go;
  assign dmar_next = {dbar, doff} + D_ADDR_WIDTH'(1);
  assign inc_go    = dmar_inc && !(put_enable && ((put_addr == ADDR_DBAR) || (put_addr == ADDR_DOFF)));
`else
  // Without auto-increment the request input has no effect.
  logic unused_dmar_inc;
  assign unused_dmar_inc = dmar_inc;
`endif

  // Address registers: PUT loads (bases truncated), optional DMAR post-increment yields to a PUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dbar <= '0;
      doff <= '0;
      ibar <= '0;
      ioff <= '0;
    end else if (!busy) begin
`ifdef REGFILE_DMAR_AUTOINC_EN
      if (inc_go) {dbar, doff} <= dmar_next;
`endif
      if (put_ok) begin
        case (put_addr)
          ADDR_DBAR: dbar <= acc[DBAR_W-1:0];
          ADDR_DOFF: doff <= acc;
          ADDR_IBAR: ibar <= acc[IBAR_W-1:0];
          ADDR_IOFF: ioff <= acc;
          default:   ;
        endcase
      end
    end
  end

  // Context FSM: accepts push/pop in IDLE, saves shadows on push, completes one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CTX_IDLE;
      depth <= '0;
      busy  <= 1'b0;
      ack   <= 1'b0;
      err   <= 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        shadow_acc[b]    <= '0;
        shadow_status[b] <= '0;
      end
    end else begin
      ack <= 1'b0;
      case (state)
        CTX_IDLE: begin
          if (!ack) begin
            if (push_legal) begin
              shadow_acc[depth]    <= acc;
              shadow_status[depth] <= status;
              state                <= CTX_PUSH;
              busy                 <= 1'b1;
            end else if (pop_legal) begin
              state <= CTX_POP;
              busy  <= 1'b1;
            end else if (ctx_push_req || ctx_pop_req) begin
              err <= 1'b1;
              ack <= 1'b1;
            end
          end
        end
        CTX_PUSH: begin
          depth <= depth + DEPTH_W'(1);
          state <= CTX_IDLE;
          busy  <= 1'b0;
          ack   <= 1'b1;
        end
        CTX_POP: begin
          depth <= depth - DEPTH_W'(1);
          state <= CTX_IDLE;
          busy  <= 1'b0;
          ack   <= 1'b1;
        end
        default: begin
          state <= CTX_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign acc_out   = acc;
  assign dmar      = {dbar, doff};
  assign imar      = {ibar, ioff};
  assign ctx_ack   = ack;
  assign ctx_busy  = busy;
  assign ctx_depth = depth;
  assign ctx_err   = err;

endmodule

// File: doc/banked_register_file.md
# banked_register_file

Parametrised successor to the single-bank accumulator register file. It provides NUM_BANKS banked copies of the general-purpose registers, with hardware context push/pop that saves and restores ACC and STATUS. It has two independent mux-based read ports in place of tristate buses, and optional DMAR post-increment. It sits between the decoder/ALU and the memory address path of the CPU datapath.

## Interface
Parameters:
- DATA_W, 8, register width
- I_ADDR_WIDTH, 12, IMAR width (must exceed DATA_W)
- D_ADDR_WIDTH, 12, DMAR width (must exceed DATA_W)
- NUM_GPR, 8, GPRs per bank (power of 2, ≤ 8)
- NUM_BANKS, 4, context depth (≥ 2); DEPTH_W = $clog2(NUM_BANKS)
- REG_ADDR_WIDTH, 4, register address width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- acc_out  out  DATA_W  live ACC value
- acc_in  in  DATA_W  external ACC write data
- acc_write_enable  in  1  write ACC
- acc_src_sel  in  1  0: ACC ← acc_in; 1: ACC ← rd_data_a
- put_enable  in  1  write ACC into register put_addr
- put_addr  in  REG_ADDR_WIDTH  PUT destination
- rd_addr_a, rd_addr_b  in  REG_ADDR_WIDTH  read addresses
- rd_data_a, rd_data_b  out  DATA_W  combinational read data
- status_write_enable  in  1  load ALU flags
- flags  in  4  {V,C,N,Z}, bits 3..0
- dmar_inc  in  1  post-increment DMAR
- dmar  out  D_ADDR_WIDTH  {DBAR, DOFF}
- imar  out  I_ADDR_WIDTH  {IBAR, IOFF}
- ctx_push_req, ctx_pop_req  in  1  context requests
- ctx_ack  out  1  one-cycle completion pulse
- ctx_busy  out  1  context operation in progress
- ctx_depth  out  DEPTH_W  active bank index
- ctx_err  out  1  sticky illegal-request flag

## Operation
- Register address map: 0–7 R0–R7 of the active bank, 8 ACC, 9 DBAR, 10 DOFF, 11 IBAR, 12 IOFF, 13 STATUS.
  - Reads of other addresses, and of GPR indices ≥ NUM_GPR, return 0.
  - DBAR and IBAR reads are zero-extended to DATA_W.
- Reads have no write bypass: a read returns the pre-edge value.
- PUT writes the pre-edge ACC.
  - PUT to DBAR/IBAR truncates to the low bits.
  - PUT to STATUS loads all DATA_W bits.
  - PUT to ACC or an unmapped address is ignored.
- Write precedence within a cycle:
  - status_write_enable overrides PUT on STATUS bits 3..0; upper status bits come from the PUT.
  - PUT to DOFF/DBAR overrides dmar_inc.
- Context FSM has three states: IDLE, PUSH, POP.
- In IDLE with ctx_ack low, requests are sampled on each edge:
  - push only, depth < NUM_BANKS−1: shadow_acc[depth] ← ACC, shadow_status[depth] ← STATUS; go to PUSH.
  - pop only, depth > 0: go to POP.
  - push at max depth, pop at depth 0, or push and pop together: no state change; ctx_err set; ctx_ack pulses.
- PUSH → IDLE: depth ← depth+1. ACC and STATUS keep their live values. The new bank's GPRs keep their prior contents and are not cleared.
- POP → IDLE: ACC ← shadow_acc[depth−1], STATUS ← shadow_status[depth−1], depth ← depth−1.
- While ctx_busy is high, acc_write_enable, put_enable, status_write_enable and dmar_inc are dropped. Reads stay valid from the pre-switch bank.
- ctx_err stays set until reset.

## Timing
- Reset values:
  - Cleared: all GPRs in every bank, ACC, DBAR, DOFF, IBAR, IOFF, STATUS, the shadows, depth, ctx_busy, ctx_ack and ctx_err.
  - rd_data_a/b = 0 and dmar = imar = 0.
  - FSM returns to IDLE.
- Register writes become visible one cycle after the enabling edge.
- A legal push/pop is accepted at edge E0, and ctx_busy is high for the cycle that follows.
  - At edge E1, ctx_depth updates and the FSM returns to IDLE.
  - ctx_ack is high for exactly one cycle after E1.
- An illegal request gives ctx_ack and ctx_err one cycle after the sampling edge.
- Requests are ignored while ctx_busy or ctx_ack is high. The requester must drop its request on ctx_ack.
- Asserting reset_n low mid-operation aborts the push/pop immediately; all state is reset.

## Configuration
- REGFILE_DMAR_AUTOINC_EN:
  - Defined: when dmar_inc is high, {DBAR,DOFF} ← {DBAR,DOFF}+1 modulo 2^D_ADDR_WIDTH. A DOFF carry propagates into DBAR.
  - Undefined: dmar_inc is ignored, with no increment logic.

## Test plan
- Reset, then PUT 0x5A to R3; read R3 on port A and ACC on port B in the same cycle. Expect 0x5A and 0x5A, with the port A value visible one cycle after the PUT.
- R2=0x11 in bank 0, then push. Expect ctx_ack 2 cycles after request and depth=1. Write R2=0x22, then pop. Expect R2=0x11, and ACC/STATUS restored to their pre-push values.
- Push NUM_BANKS−1 times, then push once more. Expect ctx_err=1, ctx_ack after 1 cycle, and depth unchanged at 3. A subsequent pop still succeeds.
- Assert push and pop together in IDLE. Expect ctx_err=1 and depth unchanged.
- With REGFILE_DMAR_AUTOINC_EN defined, DBAR=0x3 and DOFF=0xFF, pulse dmar_inc. Expect dmar=0x400. From dmar=0xFFF, expect 0x000.
- Same cycle: status_write_enable with flags=0b1010 and PUT ACC=0xF0 to STATUS. Expect STATUS=0xFA.
